muldiv_issue_ctrl: RTL and testbench
====================================

MULDIV_ISSUE_CTRL -- requirements
Module: muldiv_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles before the operation is aborted.
REQ-002 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline request present.
REQ-005 SHALL have port req_op  input  alu_op_type  requested operation.
REQ-006 SHALL have ports req_rs1 and req_rs2  input  XLEN_WIDTH  operands.
REQ-007 SHALL have port req_rd  input  5  destination register tag.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle.
REQ-009 SHALL have port stall  output  1  equal to req_valid AND NOT req_ready.
REQ-010 SHALL have port flush  input  1  kill the in-flight operation.
REQ-011 SHALL have ports md_start  output  1; md_operation  output  alu_op_type; md_operand1 and md_operand2  output  XLEN_WIDTH.
- These drive the mul/div unit.
REQ-012 SHALL have ports md_result  input  XLEN_WIDTH; md_ready  input  1; md_exception  input  1.
- These come from the mul/div unit.
REQ-013 SHALL have ports rsp_valid  output  1; rsp_result  output  XLEN_WIDTH; rsp_rd  output  5; rsp_exception  output  1; rsp_ready  input  1.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 SHALL assert req_ready only in IDLE with flush=0.
- Acceptance = req_valid AND req_ready; it latches op, operands and rd.
REQ-016 On accepting MUL, MULH, DIV, DIVU, REM or REMU, SHALL go IDLE->ISSUE.
REQ-017 On accepting any other op, SHALL go IDLE->RESP with result 0 and exception 0, and SHALL NOT pulse md_start.
REQ-018 In ISSUE, SHALL assert md_start for exactly one cycle, then go ISSUE->WAIT.
REQ-019 SHALL hold md_operation and md_operand1/2 stable from ISSUE until WAIT exits.
REQ-020 SHALL sample md_ready only in WAIT.
- On md_ready=1: capture md_result and md_exception, go WAIT->RESP.
REQ-021 SHALL count WAIT cycles from 0 in a counter.
- If the count reaches TIMEOUT_CYCLES with md_ready=0: go to RESP with rsp_result=0 and rsp_exception=1.
REQ-022 In RESP, SHALL assert rsp_valid and hold rsp_result, rsp_rd and rsp_exception stable.
- On rsp_ready=1: go RESP->IDLE.
REQ-023 Flush in ISSUE or WAIT SHALL set a kill flag, and the sequence SHALL still complete the unit handshake.
- On completion it SHALL go to IDLE with no rsp_valid.
REQ-024 Flush in RESP SHALL drop the response and go to IDLE next cycle.
REQ-025 Flush and req_valid together in IDLE SHALL NOT accept the request.
REQ-026 Flush and md_ready together in WAIT SHALL discard the result and go to IDLE.
REQ-027 Minimum mul/div latency, from acceptance to rsp_valid, SHALL be 2 + unit latency cycles.

Reset
REQ-028 Reset SHALL force the FSM to IDLE and clear the kill flag, the timeout counter and all latched fields.
REQ-029 During and after reset, outputs SHALL be: md_start=0, rsp_valid=0, rsp_result=0, rsp_rd=0, rsp_exception=0, req_ready=1.
REQ-030 Reset mid-operation SHALL abandon the operation with no response.
- md_ready arriving after reset while in IDLE SHALL be ignored.

Configuration
REQ-031 Macro MULDIV_RESULT_CACHE_EN SHALL enable the result cache; when defined:
- Store op, operands and result of the last non-exception, non-killed completion.
- An accepted request with identical op and operands SHALL go IDLE->RESP with the cached result and no md_start.
- The cache SHALL be invalidated by reset, timeout, exception and flush.
REQ-032 Without MULDIV_RESULT_CACHE_EN, every mul/div request SHALL go through ISSUE and WAIT.

Verification
REQ-033 MUL, rs1=6, rs2=7, md_ready 3 cycles after md_start -> one md_start pulse; rsp_valid with rsp_result=42 and rsp_rd equal to the request rd.
REQ-034 DIV, rs1=7, rs2=0, md_exception=1 -> rsp_exception=1; stall=1 while a second req_valid is held.
REQ-035 Flush 2 cycles after md_start -> no rsp_valid; back in IDLE after md_ready.
REQ-036 md_ready never asserted, TIMEOUT_CYCLES=64 -> rsp_valid with rsp_exception=1 and rsp_result=0 after 64 WAIT cycles.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp fields stable, req_ready=0, then IDLE one cycle after rsp_ready=1.
REQ-038 With MULDIV_RESULT_CACHE_EN, DIVU 100/7 issued twice -> second response is 14 with no md_start; without the macro, md_start is pulsed twice.

Source files
------------

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: sequences one pipeline request at a time through an
// external multiply/divide unit and returns a single registered response.
// Flow: IDLE -> ISSUE -> WAIT -> RESP, with a bounded WAIT and a kill path for flushes.
// Optional feature: define MULDIV_RESULT_CACHE_EN to reuse the result of the last
// clean mul/div completion when the same op and operands are requested again.

package muldiv_pkg;
  localparam int XLEN_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_type;
endpackage

module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // pipeline request side
  input  logic                  req_valid,
  input  alu_op_type            req_op,
  input  logic [XLEN_WIDTH-1:0] req_rs1,
  input  logic [XLEN_WIDTH-1:0] req_rs2,
  input  logic [4:0]            req_rd,
  output logic                  req_ready,
  output logic                  stall,
  input  logic                  flush,
  // mul/div unit side
  output logic                  md_start,
  output alu_op_type            md_operation,
  output logic [XLEN_WIDTH-1:0] md_operand1,
  output logic [XLEN_WIDTH-1:0] md_operand2,
  input  logic [XLEN_WIDTH-1:0] md_result,
  input  logic                  md_ready,
  input  logic                  md_exception,
  // response side
  output logic                  rsp_valid,
  output logic [XLEN_WIDTH-1:0] rsp_result,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_exception,
  input  logic                  rsp_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic                  kill_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  md_start_q;
  logic                  rsp_valid_q;
  alu_op_type            op_q;
  logic [XLEN_WIDTH-1:0] rs1_q;
  logic [XLEN_WIDTH-1:0] rs2_q;
  logic [4:0]            rd_q;
  logic [XLEN_WIDTH-1:0] result_q;
  logic                  exc_q;

  logic                  accept;
  logic                  timeout_hit;
  logic                  cache_hit;
  logic [XLEN_WIDTH-1:0] cache_result;

  function automatic logic is_muldiv(input alu_op_type op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // A flush in IDLE blocks acceptance so the killed stream cannot slip a request in.
  assign req_ready   = (state_q == S_IDLE) && !flush;
  assign stall       = req_valid && !req_ready;
  assign accept      = req_valid && req_ready;
  // Last WAIT cycle: the count started at 0 on WAIT entry.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign md_start      = md_start_q;
  assign md_operation  = op_q;
  assign md_operand1   = rs1_q;
  assign md_operand2   = rs2_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = result_q;
  assign rsp_rd        = rd_q;
  assign rsp_exception = exc_q;

`ifdef MULDIV_RESULT_CACHE_EN
  logic                  cache_vld_q;
  alu_op_type            cache_op_q;
  logic [XLEN_WIDTH-1:0] cache_rs1_q;
  logic [XLEN_WIDTH-1:0] cache_rs2_q;
  logic [XLEN_WIDTH-1:0] cache_res_q;

  // Only mul/div ops are ever stored, so an op match implies a mul/div request.
  assign cache_hit    = cache_vld_q && (req_op == cache_op_q) &&
                        (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q);
  assign cache_result = cache_res_q;

  // Remember the last clean unit completion; any flush, exception or timeout drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld_q <= 1'b0;
      cache_op_q  <= OP_ADD;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_res_q <= '0;
    end else if (flush) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (md_ready) begin
        if (md_exception || kill_q) begin
          cache_vld_q <= 1'b0;
        end else begin
          cache_vld_q <= 1'b1;
          cache_op_q  <= op_q;
          cache_rs1_q <= rs1_q;
          cache_rs2_q <= rs2_q;
          cache_res_q <= md_result;
        end
      end else if (timeout_hit) begin
        cache_vld_q <= 1'b0;
      end
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // Main sequencer: request capture, unit handshake, timeout and response hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      md_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_q        <= OP_ADD;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            rd_q   <= req_rd;
            kill_q <= 1'b0;
            cnt_q  <= '0;
            if (is_muldiv(req_op) && !cache_hit) begin
              // md_start is registered so it is high for the whole ISSUE cycle.
              state_q    <= S_ISSUE;
              md_start_q <= 1'b1;
            end else begin
              // Non mul/div ops answer 0; a cache hit answers the stored result.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              result_q    <= cache_hit ? cache_result : '0;
              exc_q       <= 1'b0;
            end
          end
        end

        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
          if (flush) kill_q <= 1'b1;
        end

        S_WAIT: begin
          if (md_ready) begin
            if (kill_q || flush) begin
              // Killed: the unit handshake is done, drop the result silently.
              state_q <= S_IDLE;
              kill_q  <= 1'b0;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              result_q    <= md_result;
              exc_q       <= md_exception;
            end
          end else if (timeout_hit) begin
            if (kill_q || flush) begin
              state_q <= S_IDLE;
              kill_q  <= 1'b0;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              result_q    <= '0;
              exc_q       <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (flush) kill_q <= 1'b1;
          end
        end

        S_RESP: begin
          if (flush || rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Testbench for muldiv_issue_ctrl: directed scenarios followed by randomized
// requests, a behavioural mul/div unit, and a queue-based response scoreboard.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  alu_op_type  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        req_ready, stall, flush;
  logic        flush_unit, flush_resp, flush_dir;
  logic        md_start;
  alu_op_type  md_operation;
  logic [31:0] md_operand1, md_operand2, md_result;
  logic        md_ready, md_exception;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_rd;
  logic        rsp_exception, rsp_ready;

  assign flush = flush_unit | flush_resp | flush_dir;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_ready(req_ready), .stall(stall), .flush(flush),
    .md_start(md_start), .md_operation(md_operation), .md_operand1(md_operand1),
    .md_operand2(md_operand2), .md_result(md_result), .md_ready(md_ready),
    .md_exception(md_exception),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_rd(rsp_rd),
    .rsp_exception(rsp_exception), .rsp_ready(rsp_ready)
  );

  typedef struct { logic [31:0] result; logic [4:0] rd; logic exc; } exp_t;
  typedef struct { int lat; bit no_resp; int flush_at; } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    md_start_seen = 0;
  int    md_start_exp = 0;
  bit    unit_busy = 1'b0;
  bit    allow_resp_flush = 1'b0;
  bit    hold_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  function automatic bit is_md(input alu_op_type op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Reference arithmetic of the mul/div unit (RISC-V M semantics).
  function automatic logic [31:0] md_ref(input alu_op_type op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:  return a * b;
      OP_MULH: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp[63:32];
      end
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic md_exc(input alu_op_type op, input logic [31:0] b);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (b == 0);
  endfunction

  // Behavioural mul/div unit: follows the plan queued with each issued request.
  initial begin
    plan_t p;
    alu_op_type op;
    logic [31:0] a, b;
    int last;
    md_ready = 1'b0; md_result = '0; md_exception = 1'b0; flush_unit = 1'b0;
    forever begin
      @(posedge clk); #1;
      md_ready = 1'b0; md_exception = 1'b0; flush_unit = 1'b0;
      if (md_start) begin
        if (plan_q.size() == 0) begin
          check("unplanned_md_start", 32'(md_start), 32'h0);
        end else begin
          p = plan_q.pop_front();
          op = md_operation; a = md_operand1; b = md_operand2;
          unit_busy = 1'b1;
          last = p.no_resp ? TO : p.lat;
          for (int c = 0; c <= last; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            flush_unit = (c == p.flush_at);
            md_ready   = !p.no_resp && (c == p.lat);
            md_result  = md_ready ? md_ref(op, a, b) : $urandom;
            md_exception = md_ready ? md_exc(op, b) : 1'($urandom);
          end
          unit_busy = 1'b0;
        end
      end
    end
  end

  // Response-side driver: random back-pressure with occasional long holds and RESP flushes.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    rsp_ready = 1'b0; flush_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      flush_resp = 1'b0;
      if (hold_low) begin
        rsp_ready = 1'b0;
      end else if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else if ($urandom_range(0, 11) == 0) begin
        rsp_ready = 1'b0;
        hold_cnt = int'($urandom_range(4, 7));
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (allow_resp_flush && rsp_valid && !reset && $urandom_range(0, 15) == 0)
        flush_resp = 1'b1;
    end
  end

  // Monitor: pops expected responses on each handshake and checks hold/stall rules.
  initial begin
    bit hold_prev;
    logic [31:0] r_prev;
    logic [4:0] rd_prev;
    logic e_prev;
    exp_t e;
    hold_prev = 1'b0; r_prev = '0; rd_prev = '0; e_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin hold_prev = 1'b0; continue; end
      if (md_start) md_start_seen++;
      if (hold_prev) begin
        check("rsp_valid_held", 32'(rsp_valid), 32'h1);
        check("rsp_result_stable", rsp_result, r_prev);
        check("rsp_rd_stable", 32'(rsp_rd), 32'(rd_prev));
        check("rsp_exc_stable", 32'(rsp_exception), 32'(e_prev));
      end
      if (rsp_valid) begin
        check("req_ready_in_resp", 32'(req_ready), 32'h0);
        if (req_valid) check("stall_in_resp", 32'(stall), 32'h1);
      end
      if (rsp_valid && (flush || rsp_ready)) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          if (!flush) begin
            check("rsp_result", rsp_result, e.result);
            check("rsp_rd", 32'(rsp_rd), 32'(e.rd));
            check("rsp_exception", 32'(rsp_exception), 32'(e.exc));
          end
        end
      end
      hold_prev = rsp_valid && !rsp_ready && !flush;
      r_prev = rsp_result; rd_prev = rsp_rd; e_prev = rsp_exception;
    end
  end

  // Present one request, queue its plan/expectation, and return right after acceptance.
  task automatic issue(input alu_op_type op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input bit no_resp,
                       input int flush_at, input bit use_unit, input bit expect_rsp);
    exp_t e;
    bit killed, acc;
    killed = use_unit && (flush_at >= 0) && (no_resp ? (flush_at <= TO) : (flush_at <= lat));
    if (use_unit) begin
      plan_q.push_back('{lat: lat, no_resp: no_resp, flush_at: flush_at});
      md_start_exp++;
    end
    if (expect_rsp && !killed) begin
      if (!is_md(op))              e = '{result: 32'h0, rd: rd, exc: 1'b0};
      else if (use_unit && no_resp) e = '{result: 32'h0, rd: rd, exc: 1'b1};
      else                          e = '{result: md_ref(op, a, b), rd: rd, exc: md_exc(op, b)};
      exp_q.push_back(e);
    end
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    acc = 1'b0;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      check("accept_timeout", 32'(acc), 32'h1);
      finish_run();
    end
  endtask

  // Wait until every expected response is drained and the controller is idle again.
  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 3000 && !idle; n++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !unit_busy && !rsp_valid && req_ready;
    end
    if (!idle) begin
      check("idle_timeout", 32'(idle), 32'h1);
      finish_run();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    check("watchdog", 32'h1, 32'h0);
    finish_run();
  end

  initial begin
    alu_op_type op;
    logic [31:0] a, b;
    int lat, fa;
    bit nr, md, got;
    reset = 1'b1; req_valid = 1'b0; req_op = OP_ADD; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; flush_dir = 1'b0;

    // Outputs while reset is held and just after release.
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_md_start", 32'(md_start), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_result", rsp_result, 32'h0);
      check("rst_rsp_rd", 32'(rsp_rd), 32'h0);
      check("rst_rsp_exception", 32'(rsp_exception), 32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;
    end

    // MUL 6*7 with a 3-cycle unit.
    issue(OP_MUL, 32'd6, 32'd7, 5'd9, 3, 1'b0, -1, 1'b1, 1'b1);
    req_valid = 1'b0; wait_idle();

    // DIV 7/0 with a second request held behind it (stall while busy).
    issue(OP_DIV, 32'd7, 32'd0, 5'd3, 2, 1'b0, -1, 1'b1, 1'b1);
    issue(OP_ADD, 32'd1, 32'd2, 5'd4, 0, 1'b0, -1, 1'b0, 1'b1);
    req_valid = 1'b0; wait_idle();

    // Flush 2 cycles after md_start, flush in ISSUE, flush together with md_ready.
    issue(OP_REM, 32'd50, 32'd9, 5'd7, 5, 1'b0, 2, 1'b1, 1'b1);
    req_valid = 1'b0; wait_idle();
    issue(OP_MULH, 32'hFFFF_FFF0, 32'd3, 5'd8, 4, 1'b0, 0, 1'b1, 1'b1);
    req_valid = 1'b0; wait_idle();
    issue(OP_REMU, 32'd77, 32'd5, 5'd10, 4, 1'b0, 4, 1'b1, 1'b1);
    req_valid = 1'b0; wait_idle();

    // Unit never answers: timeout response.
    issue(OP_DIVU, 32'd10, 32'd3, 5'd11, 0, 1'b1, -1, 1'b1, 1'b1);
    req_valid = 1'b0; wait_idle();

    // Response held off for several cycles.
    hold_low = 1'b1;
    issue(OP_MUL, 32'd12, 32'd12, 5'd12, 2, 1'b0, -1, 1'b1, 1'b1);
    req_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin @(negedge clk); got = rsp_valid; end
    check("hold_rsp_seen", 32'(got), 32'h1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    hold_low = 1'b0;
    wait_idle();

    // Flush with req_valid in IDLE must not accept.
    req_valid = 1'b1; req_op = OP_MUL; req_rs1 = 32'd2; req_rs2 = 32'd2; req_rd = 5'd1;
    flush_dir = 1'b1;
    @(negedge clk);
    check("flush_idle_req_ready", 32'(req_ready), 32'h0);
    check("flush_idle_stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    flush_dir = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_no_start", 32'(md_start), 32'h0);
    check("flush_idle_still_idle", 32'(req_ready), 32'h1);
    @(posedge clk); #1;

    // DIVU 100/7 twice.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd13, 3, 1'b0, -1, 1'b1, 1'b1);
    req_valid = 1'b0; wait_idle();
`ifdef MULDIV_RESULT_CACHE_EN
    issue(OP_DIVU, 32'd100, 32'd7, 5'd14, 3, 1'b0, -1, 1'b0, 1'b1);
`else
    issue(OP_DIVU, 32'd100, 32'd7, 5'd14, 3, 1'b0, -1, 1'b1, 1'b1);
`endif
    req_valid = 1'b0; wait_idle();

    // Randomized traffic.
    allow_resp_flush = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = alu_op_type'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
`ifdef MULDIV_RESULT_CACHE_EN
      a = $urandom; b = $urandom;
`endif
      md  = is_md(op);
      lat = int'($urandom_range(1, 8));
      nr  = md && ($urandom_range(0, 19) == 0);
      fa  = -1;
      if (md && $urandom_range(0, 9) == 0)
        fa = nr ? int'($urandom_range(0, TO)) : int'($urandom_range(0, lat));
      issue(op, a, b, 5'($urandom), lat, nr, fa, md, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0; allow_resp_flush = 1'b0;
    wait_idle();

    // Reset in the middle of WAIT; the late md_ready must be ignored.
    issue(OP_MUL, 32'd3, 32'd5, 5'd8, 12, 1'b0, -1, 1'b1, 1'b0);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_valid), 32'h0);

    check("md_start_count", 32'(md_start_seen), 32'(md_start_exp));
    finish_run();
  end

endmodule
